// File: rtl/ms_mode_register.sv
// WIDTH-bit register with hold, parallel load, bidirectional serial shift and
// Fibonacci LFSR step modes, plus LFSR lock-up recovery, step count and seed-hit pulse.
module ms_mode_register #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
    parameter logic [WIDTH-1:0] SEED      = 8'h01,
    parameter logic [WIDTH-1:0] RESET_VAL = 8'h00,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             clock,
    input  logic             r,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             seed_hit,
    output logic [CNT_W-1:0] step_cnt
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_SHIFT = 2'b10;
    localparam logic [1:0] MODE_LFSR  = 2'b11;

    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] lfsr_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             hit_nxt;

    function automatic logic lfsr_fb(input logic [WIDTH-1:0] v);
        return ^(v & TAPS);
    endfunction

    assign sout     = dir ? q[0] : q[WIDTH-1];
    assign lfsr_nxt = {q[WIDTH-2:0], lfsr_fb(q)};

    always_comb begin
        q_nxt   = q;
        cnt_nxt = step_cnt;
        hit_nxt = 1'b0;
        unique case (mode)
            MODE_HOLD: begin
                q_nxt = q;
            end
            MODE_LOAD: begin
                q_nxt   = d;
                cnt_nxt = '0;
            end
            MODE_SHIFT: begin
                if (dir) q_nxt = {sin, q[WIDTH-1:1]};
                else     q_nxt = {q[WIDTH-2:0], sin};
            end
            MODE_LFSR: begin
                // All-zero state never advances; recovering from it is not a period event.
                if (q == '0) begin
                    q_nxt   = SEED;
                    cnt_nxt = '0;
                end else begin
                    q_nxt = lfsr_nxt;
                    if (lfsr_nxt == SEED) begin
                        hit_nxt = 1'b1;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = step_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                q_nxt = q;
            end
        endcase
    end

    always_ff @(posedge clock or posedge r) begin
        if (r) begin
            q        <= RESET_VAL;
            step_cnt <= '0;
            seed_hit <= 1'b0;
        end else begin
            q        <= q_nxt;
            step_cnt <= cnt_nxt;
            seed_hit <= hit_nxt;
        end
    end

endmodule

// File: doc/ms_mode_register.md
Name: ms_mode_register

Overview:
- Parametrised successor to the fixed 8-bit master-slave register.
- WIDTH-bit edge-triggered register with four modes: hold, parallel load, bidirectional serial shift, and Fibonacci LFSR step.
- LFSR mode includes lock-up recovery, a step counter, and a period-detect pulse.
- Used as the general storage/pattern-generator element in the flip-flop/LFSR lab datapaths.

Parameters:
- WIDTH, 8, register width in bits (>= 2)
- TAPS, 8'hB8, feedback tap mask, WIDTH bits; bit i set => q[i] enters the XOR (default is maximal-length x^8+x^6+x^5+x^4+1)
- SEED, 8'h01, value loaded on LFSR lock-up; must be nonzero
- RESET_VAL, 8'h00, value of q after reset
- CNT_W, 16, width of the LFSR step counter

Ports:
- clock  in  1  rising-edge clock
- r  in  1  asynchronous active-high reset
- mode  in  2  operation select: 00 hold, 01 load, 10 shift, 11 lfsr
- d  in  WIDTH  parallel load data
- sin  in  1  serial input for shift mode
- dir  in  1  shift direction: 0 left (toward MSB), 1 right
- q  out  WIDTH  register contents
- sout  out  1  serial output, combinational: dir=0 -> q[WIDTH-1], dir=1 -> q[0]
- seed_hit  out  1  registered one-cycle pulse when an LFSR step lands on SEED
- step_cnt  out  CNT_W  number of LFSR steps since the last seed event

Behaviour:
- Reset:
  - r=1 immediately forces q=RESET_VAL, seed_hit=0, step_cnt=0, independent of clock.
  - Reset has priority over all modes.
  - While r=1, rising edges are ignored.
  - First update occurs on the first rising edge after r falls.
  - Deasserting reset mid-sequence gives no partial state.
- All state updates occur on the rising edge of clock; latency is one cycle from inputs to q.
- mode 00 (hold): q unchanged; step_cnt unchanged; seed_hit=0.
- mode 01 (load): q<=d; step_cnt<=0; seed_hit=0.
- mode 10 (shift):
  - dir=0: q<={q[WIDTH-2:0], sin}.
  - dir=1: q<={sin, q[WIDTH-1:1]}.
  - step_cnt unchanged; seed_hit=0.
- mode 11 (lfsr):
  - Feedback: fb = XOR over i of (q[i] & TAPS[i]).
  - Lock-up: if q==0, q<=SEED, step_cnt<=0, seed_hit<=0 (recovery is not a period event).
  - Otherwise q<={q[WIDTH-2:0], fb} and step_cnt<=step_cnt+1.
  - If that next q equals SEED: seed_hit<=1 and step_cnt<=0 (the clear overrides the increment).
  - Otherwise seed_hit<=0.
- step_cnt wraps modulo 2^CNT_W with no saturation and no flag.
- seed_hit is high for exactly the one cycle following the edge that produced q==SEED; it never stays high across consecutive edges unless consecutive steps each land on SEED.
- Mode changes take effect on the next edge. No state is carried between modes except q and step_cnt.
- Inputs with unknown values are not required to be handled; the bench drives defined values.

Test Plan:
- Reset: r=1 asynchronously mid-cycle with q=8'h5A -> q=8'h00, step_cnt=0, seed_hit=0 before the next edge; edges during reset leave q=0.
- Load/hold: mode=01, d=8'hA5, one edge -> q=8'hA5; mode=00 for 5 edges -> q stays 8'hA5.
- Shift:
  - From q=8'h81, dir=0, sin=1, one edge -> q=8'h03, sout=0.
  - Then dir=1, sin=0, one edge -> q=8'h01, sout=1.
- LFSR lock-up and first steps: reset (q=0), mode=11:
  - Edge 1 -> q=8'h01, step_cnt=0.
  - Edge 2 -> q=8'h02, step_cnt=1.
  - Edge 3 -> q=8'h04, step_cnt=2.
- LFSR period: after q=8'h01 with step_cnt=0, run 255 mode-11 edges -> q returns to 8'h01 on edge 255, seed_hit=1 for that cycle only, step_cnt=0. Also check that all 255 nonzero values appear exactly once.
- Mixed: during the LFSR run, insert mode=00 for 3 cycles -> q and step_cnt frozen; resuming mode=11 continues the sequence unchanged. Separately, mode=01 with d=8'h01 -> step_cnt=0.
